// File: rtl/fetch_stage_pkg.sv
// Shared core definitions for the instruction fetch stage: FSM encoding,
// reset/bubble constants and the IF/ID payload type.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;  // addi x0,x0,0

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,  // request outstanding
        ST_HOLD  = 2'd1,  // word captured while decode is stalled
        ST_DROP  = 2'd2   // request outstanding, response will be discarded
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } if_id_t;

    function automatic logic [31:0] align4(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory request/response channel between fetch and imem.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
    modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush wins over load, no-op holds the contents.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        flush_i,
    input  if_id_t      d_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    output logic        valid_o
);

    logic [31:0] inst_q, pc_q, pc4_q;
    logic        valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_q  <= NOP_INST;
            pc_q    <= 32'h0;
            pc4_q   <= 32'h4;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            // pc is left alone so a bubble still carries its last address
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else if (load_i) begin
            inst_q  <= d_i.inst;
            pc_q    <= d_i.pc;
            pc4_q   <= d_i.pc + 32'd4;
            valid_q <= 1'b1;
        end
    end

    assign inst_o  = inst_q;
    assign pc_o    = pc_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: request FSM, PC, one-entry stall buffer and the
// IF/ID register, with redirect taking priority over stall and ack.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [31:0]           redirect_pc_i,
    fetch_stage_if.master         imem,
    output logic [31:0]           if_id_inst_o,
    output logic [31:0]           if_id_pc_o,
    output logic [31:0]           if_id_pc4_o,
    output logic                  if_id_valid_o
);

    fetch_state_e state_q;
    logic [31:0]  pc_q, req_addr_q;
    logic         req_q;
    if_id_t       buf_q;
    logic         buf_vld_q;

    logic         ack;
    logic [31:0]  tgt;
    logic         load, flush;
    if_id_t       ld_data;

    assign ack = imem.imem_ack & imem.imem_req;
    assign tgt = align4(redirect_pc_i);

    always_comb begin
        load         = 1'b0;
        ld_data.inst = imem.imem_rdata;
        ld_data.pc   = req_addr_q;
        if (!redirect_i && !stall_i) begin
            case (state_q)
                ST_FETCH: load = ack;
                ST_HOLD: begin
                    load    = buf_vld_q;
                    ld_data = buf_q;
                end
                default: load = 1'b0;
            endcase
        end
        // decode consumes the word whenever it is not stalled, so an empty
        // cycle must show a bubble rather than repeat the last instruction
        flush = redirect_i | (~stall_i & ~load);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            req_q      <= 1'b1;
            buf_q      <= '0;
            buf_vld_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (redirect_i) begin
                        pc_q      <= tgt;
                        buf_vld_q <= 1'b0;
                        if (ack) req_addr_q <= tgt;
                        else     state_q    <= ST_DROP;
                    end else if (ack) begin
                        if (stall_i) begin
                            buf_q.inst <= imem.imem_rdata;
                            buf_q.pc   <= req_addr_q;
                            buf_vld_q  <= 1'b1;
                            req_q      <= 1'b0;
                            state_q    <= ST_HOLD;
                        end else begin
                            req_addr_q <= req_addr_q + 32'd4;
                            pc_q       <= req_addr_q + 32'd4;
                        end
                    end
                end
                ST_HOLD: begin
                    if (redirect_i) begin
                        pc_q       <= tgt;
                        req_addr_q <= tgt;
                        buf_vld_q  <= 1'b0;
                        req_q      <= 1'b1;
                        state_q    <= ST_FETCH;
                    end else if (!stall_i) begin
                        req_addr_q <= buf_q.pc + 32'd4;
                        pc_q       <= buf_q.pc + 32'd4;
                        buf_vld_q  <= 1'b0;
                        req_q      <= 1'b1;
                        state_q    <= ST_FETCH;
                    end
                end
                ST_DROP: begin
                    // the redirect target parks in pc until the stale ack lands
                    if (redirect_i) pc_q <= tgt;
                    if (ack) begin
                        req_addr_q <= redirect_i ? tgt : pc_q;
                        state_q    <= ST_FETCH;
                    end
                end
                default: begin
                    req_q   <= 1'b1;
                    state_q <= ST_FETCH;
                end
            endcase
        end
    end

    assign imem.imem_req  = req_q & ~rst;
    assign imem.imem_addr = req_addr_q;

    if_id_reg #(.NOP_INST(NOP_INST)) u_if_id (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .flush_i (flush),
        .d_i     (ld_data),
        .inst_o  (if_id_inst_o),
        .pc_o    (if_id_pc_o),
        .pc4_o   (if_id_pc4_o),
        .valid_o (if_id_valid_o)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed corner cases then random
// stall/redirect/ack traffic against a transaction-level fetch model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, redirect;
    logic [31:0] rpc;
    logic [31:0] if_id_inst, if_id_pc, if_id_pc4;
    logic        if_id_valid;

    fetch_stage_if imem_if ();

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (rpc),
        .imem          (imem_if),
        .if_id_inst_o  (if_id_inst),
        .if_id_pc_o    (if_id_pc),
        .if_id_pc4_o   (if_id_pc4),
        .if_id_valid_o (if_id_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        req;
        logic [31:0] addr;
    } snap_t;

    snap_t exp_q[$];
    int n_cmp = 0, n_bad = 0;

    // Reference model: what decode sees and which address memory is asked for.
    logic        m_valid, m_req, m_drop;
    logic [31:0] m_inst, m_pc, m_fetch, m_after, h_inst, h_pc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_inst = NOP; m_pc = 32'h0;
        m_req = 1'b1; m_fetch = 32'h0; m_drop = 1'b0; m_after = 32'h0;
    endtask

    task automatic bubble();
        m_valid = 1'b0; m_inst = NOP;
    endtask

    task automatic put(input logic [31:0] w, input logic [31:0] a);
        m_valid = 1'b1; m_inst = w; m_pc = a;
    endtask

    // Called at a negedge: drive one cycle, predict the post-edge view, advance.
    task automatic step(input logic s, input logic r, input logic a,
                        input logic [31:0] t, input logic [31:0] d);
        logic ae;
        logic [31:0] ta;
        snap_t e;
        stall = s; redirect = r; rpc = t;
        imem_if.imem_ack = a; imem_if.imem_rdata = d;
        ae = a && m_req;
        ta = t & 32'hFFFF_FFFC;
        if (r) begin
            bubble();
            m_after = ta;
            if (!m_req) begin m_fetch = ta; m_req = 1'b1; end
            else if (m_drop) begin if (ae) begin m_fetch = ta; m_drop = 1'b0; end end
            else if (ae) m_fetch = ta;
            else m_drop = 1'b1;
        end else if (!m_req) begin
            if (!s) begin put(h_inst, h_pc); m_fetch = h_pc + 32'd4; m_req = 1'b1; end
        end else if (m_drop) begin
            if (ae) begin m_fetch = m_after; m_drop = 1'b0; end
            if (!s) bubble();
        end else if (ae) begin
            if (!s) begin put(d, m_fetch); m_fetch = m_fetch + 32'd4; end
            else begin h_inst = d; h_pc = m_fetch; m_req = 1'b0; end
        end else if (!s) bubble();
        e.valid = m_valid; e.inst = m_inst; e.pc = m_pc; e.req = m_req; e.addr = m_fetch;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic chk_reset_view(input string nm);
        chk({nm, "_inst"},  if_id_inst, NOP);
        chk({nm, "_valid"}, {31'h0, if_id_valid}, 32'h0);
        chk({nm, "_req"},   {31'h0, imem_if.imem_req}, 32'h0);
        chk({nm, "_addr"},  imem_if.imem_addr, 32'h0);
    endtask

    // 1 ns asynchronous pulse between edges; nothing is in flight in the queue.
    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        chk_reset_view("rst_pulse");
        rst = 1'b0;
        model_reset();
    endtask

    // Monitor: every post-edge view of the DUT is checked against the queue.
    always @(posedge clk) begin
        snap_t e;
        #1;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("valid", {31'h0, if_id_valid}, {31'h0, e.valid});
            chk("inst",  if_id_inst, e.inst);
            chk("pc",    if_id_pc,   e.pc);
            chk("pc4",   if_id_pc4,  e.pc + 32'd4);
            chk("req",   {31'h0, imem_if.imem_req}, {31'h0, e.req});
            if (e.req) chk("addr", imem_if.imem_addr, e.addr);
        end
    end

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; rpc = 32'h0;
        imem_if.imem_ack = 1'b0; imem_if.imem_rdata = 32'h0;
        model_reset();
        @(negedge clk); @(negedge clk);
        chk_reset_view("reset");
        chk("reset_pc",  if_id_pc,  32'h0);
        chk("reset_pc4", if_id_pc4, 32'h4);
        rst = 1'b0;

        // back-to-back acks, data = address
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 32'h0, m_fetch);
        chk("b2b_pc",   if_id_pc, 32'h8);
        chk("b2b_inst", if_id_inst, 32'h8);
        chk("b2b_addr", imem_if.imem_addr, 32'hC);

        // ack at 8 under a 3-cycle stall
        pulse_reset();
        step(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h0, 32'h4);
        step(1'b1, 1'b0, 1'b1, 32'h0, 32'h8);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("hold_pc",  if_id_pc, 32'h4);
        chk("hold_req", {31'h0, imem_if.imem_req}, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("release_pc",   if_id_pc, 32'h8);
        chk("release_addr", imem_if.imem_addr, 32'hC);

        // redirect without ack, stale ack discarded
        step(1'b0, 1'b1, 1'b0, 32'h100, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h0, 32'hDEADBEEF);
        chk("drop_valid", {31'h0, if_id_valid}, 32'h0);
        chk("drop_addr",  imem_if.imem_addr, 32'h100);

        // redirect + ack + stall together, with unaligned target bits
        step(1'b1, 1'b1, 1'b1, 32'h203, 32'h1234_5678);
        chk("redir_inst", if_id_inst, NOP);
        chk("redir_addr", imem_if.imem_addr, 32'h200);

        // address wrap
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h0, 32'hCAFE_0001);
        chk("wrap_pc4",  if_id_pc4, 32'h0);
        chk("wrap_addr", imem_if.imem_addr, 32'h0);

        // reset mid-request at 0x40, then a late ack
        step(1'b0, 1'b1, 1'b1, 32'h40, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        pulse_reset();
        step(1'b0, 1'b0, 1'b1, 32'h0, 32'hABCD_0000);
        chk("late_ack_pc",    if_id_pc, 32'h0);
        chk("late_ack_valid", {31'h0, if_id_valid}, 32'h1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            if ($urandom_range(0, 199) == 0) pulse_reset();
            case ($urandom_range(0, 3))
                0:       t = 32'hFFFF_FFFC;
                1:       t = $urandom_range(0, 255);
                default: t = $urandom;
            endcase
            step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) < 6, t, $urandom);
        end

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
